// File: rtl/signed_range_iter.sv
// signed_range_iter: hardware form of `for (i = first; i <= limit; i += step)`
// with two's-complement signed semantics. One command in, a valid/ready stream
// of indices out, then a one-cycle done pulse (with err for step <= 0).
// Optional macro SIGNED_RANGE_ITER_COUNT_EN adds a saturating beat counter
// output iter_count.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | presenting indices, idx_valid high
// FIN   | done (and err if rejected) pulse for one cycle
module signed_range_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_first,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [WIDTH-1:0] cmd_step,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [WIDTH-1:0] idx_data,
    output logic             idx_last,
    output logic             done,
    output logic             err
`ifdef SIGNED_RANGE_ITER_COUNT_EN
    ,
    output logic [CNT_W-1:0] iter_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               idx_valid_q, idx_valid_d;
    logic               idx_last_q, idx_last_d;
    logic [WIDTH-1:0]   idx_data_q, idx_data_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // One extra bit of headroom so that index + step past the signed maximum
    // compares as greater than any limit instead of wrapping negative.
    logic signed [WIDTH:0] cur_ext, step_ext, limit_ext, nxt_ext, nxt2_ext;
    logic signed [WIDTH:0] cmd_first_ext, cmd_step_ext, cmd_limit_ext, cmd_nxt_ext;

    always_comb begin
        cur_ext       = {idx_data_q[WIDTH-1], idx_data_q};
        step_ext      = {step_q[WIDTH-1], step_q};
        limit_ext     = {limit_q[WIDTH-1], limit_q};
        nxt_ext       = cur_ext + step_ext;
        // Only used when nxt_ext <= limit, so its low WIDTH bits are exact.
        nxt2_ext      = {nxt_ext[WIDTH-1], nxt_ext[WIDTH-1:0]} + step_ext;
        cmd_first_ext = {cmd_first[WIDTH-1], cmd_first};
        cmd_step_ext  = {cmd_step[WIDTH-1], cmd_step};
        cmd_limit_ext = {cmd_limit[WIDTH-1], cmd_limit};
        cmd_nxt_ext   = cmd_first_ext + cmd_step_ext;
    end

`ifdef SIGNED_RANGE_ITER_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign iter_count = cnt_q;
`endif

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        idx_valid_d = idx_valid_q;
        idx_last_d  = idx_last_q;
        idx_data_d  = idx_data_q;
        limit_d     = limit_q;
        step_d      = step_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef SIGNED_RANGE_ITER_COUNT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    limit_d     = cmd_limit;
                    step_d      = cmd_step;
`ifdef SIGNED_RANGE_ITER_COUNT_EN
                    cnt_d       = '0;
`endif
                    if (cmd_step_ext <= 0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (cmd_first_ext > cmd_limit_ext) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = S_RUN;
                        idx_valid_d = 1'b1;
                        idx_data_d  = cmd_first;
                        idx_last_d  = (cmd_nxt_ext > cmd_limit_ext);
                    end
                end
            end
            S_RUN: begin
                if (idx_ready) begin
`ifdef SIGNED_RANGE_ITER_COUNT_EN
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`endif
                    if (idx_last_q) begin
                        state_d     = S_FIN;
                        idx_valid_d = 1'b0;
                        idx_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_data_d = nxt_ext[WIDTH-1:0];
                        idx_last_d = (nxt2_ext > limit_ext);
                    end
                end
            end
            S_FIN: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                idx_valid_d = 1'b0;
                idx_last_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            idx_valid_q <= 1'b0;
            idx_last_q  <= 1'b0;
            idx_data_q  <= '0;
            limit_q     <= '0;
            step_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SIGNED_RANGE_ITER_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            idx_valid_q <= idx_valid_d;
            idx_last_q  <= idx_last_d;
            idx_data_q  <= idx_data_d;
            limit_q     <= limit_d;
            step_q      <= step_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef SIGNED_RANGE_ITER_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // cmd_ready is held low while reset is asserted.
    assign cmd_ready = cmd_ready_q & ~rst;
    assign idx_valid = idx_valid_q;
    assign idx_last  = idx_last_q;
    assign idx_data  = idx_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_signed_range_iter.sv
// Bench for signed_range_iter: a queue-based model of the loop checked every
// cycle, plus literal checks of observed beats and done latency per command.
module tb_signed_range_iter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_first = '0;
    logic [WIDTH-1:0] cmd_limit = '0;
    logic [WIDTH-1:0] cmd_step = '0;
    logic             idx_valid;
    logic             idx_ready = 1'b1;
    logic [WIDTH-1:0] idx_data;
    logic             idx_last;
    logic             done;
    logic             err;
`ifdef SIGNED_RANGE_ITER_COUNT_EN
    logic [CNT_W-1:0] iter_count;
`endif

    signed_range_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_first(cmd_first), .cmd_limit(cmd_limit), .cmd_step(cmd_step),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
        .idx_last(idx_last), .done(done), .err(err)
`ifdef SIGNED_RANGE_ITER_COUNT_EN
        , .iter_count(iter_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready pattern: mode 0 always ready, mode 1 repeats 1,0,0.
    int rmode = 0;
    int rcyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            idx_ready = (rmode == 0) ? 1'b1 : ((rcyc % 3) == 0);
            rcyc++;
        end
    end

    // Model state and observations from the DUT.
    longint qd[$];
    bit     ql[$];
    bit     armed = 0, prev_rst = 0, idle_exp = 1, done_exp = 0, err_exp = 0;
    longint cnt_exp = 0;
    int     ncyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;
    bit     err_at_done = 0;
    longint beat_d[16];
    bit     beat_l[16];
    int     nbeats = 0;

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (armed) begin
                if (prev_rst) begin
                    chk("rst_idx_valid", idx_valid, 0);
                    chk("rst_idx_last", idx_last, 0);
                    chk("rst_idx_data", idx_data, 0);
                    chk("rst_done", done, 0);
                    chk("rst_err", err, 0);
                end else begin
                    chk("idx_valid", idx_valid, qd.size() > 0);
                    if (qd.size() > 0) begin
                        chk("idx_data", $signed(idx_data), qd[0]);
                        chk("idx_last", idx_last, ql[0]);
                    end
                    chk("done", done, done_exp);
                    chk("err", err, err_exp);
                end
                chk("cmd_ready", cmd_ready, (!rst && idle_exp));
`ifdef SIGNED_RANGE_ITER_COUNT_EN
                chk("iter_count", iter_count, cnt_exp);
`endif
            end
            if (!rst && done) begin
                done_cyc = ncyc;
                done_cnt++;
                err_at_done = err;
            end
            if (!rst && idx_valid && idx_ready && nbeats < 16) begin
                beat_d[nbeats] = $signed(idx_data);
                beat_l[nbeats] = idx_last;
                nbeats++;
            end
            if (rst) begin
                qd.delete(); ql.delete();
                done_exp = 0; err_exp = 0; idle_exp = 1;
                cnt_exp = 0; prev_rst = 1; armed = 1;
            end else begin
                bit nd, ne;
                nd = 0; ne = 0;
                prev_rst = 0;
                if (qd.size() > 0 && idx_ready) begin
                    void'(qd.pop_front()); void'(ql.pop_front());
                    if (cnt_exp < (2**CNT_W - 1)) cnt_exp++;
                    if (qd.size() == 0) nd = 1;
                end
                if (done_exp) begin
                    idle_exp = 1;
                end else if (idle_exp && cmd_valid) begin
                    longint f, l, s;
                    f = longint'($signed(cmd_first));
                    l = longint'($signed(cmd_limit));
                    s = longint'($signed(cmd_step));
                    acc_cyc = ncyc; nbeats = 0; done_cnt = 0;
                    idle_exp = 0; cnt_exp = 0;
                    if (s <= 0) begin
                        nd = 1; ne = 1;
                    end else begin
                        for (longint i = f; i <= l && qd.size() < 64; i += s) begin
                            qd.push_back(i);
                            ql.push_back((i + s) > l);
                        end
                        if (qd.size() == 0) nd = 1;
                    end
                end
                done_exp = nd; err_exp = ne;
            end
        end
    end

    task automatic run_cmd(input logic [31:0] f, input logic [31:0] l,
                           input logic [31:0] s, input int mode);
        bit ok;
        rmode = mode;
        @(posedge clk); #1;
        cmd_first = f; cmd_limit = l; cmd_step = s; cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // 2 <= -1 is false: zero beats
        run_cmd(32'd2, 32'hFFFF_FFFF, 32'd1, 0);
        chk("t1_beats", nbeats, 0);
        chk("t1_latency", done_cyc - acc_cyc, 1);
        chk("t1_err", err_at_done, 0);

        run_cmd(32'hFFFF_FFFD, 32'd1, 32'd2, 0);
        chk("t2_beats", nbeats, 3);
        chk("t2_b0", beat_d[0], -3);
        chk("t2_b1", beat_d[1], -1);
        chk("t2_b2", beat_d[2], 1);
        chk("t2_last0", beat_l[0], 0);
        chk("t2_last2", beat_l[2], 1);
        chk("t2_latency", done_cyc - acc_cyc, 4);
`ifdef SIGNED_RANGE_ITER_COUNT_EN
        chk("t2_iter_count", iter_count, 3);
`endif

        run_cmd(32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'd2, 0);
        chk("t3_beats", nbeats, 1);
        chk("t3_b0", beat_d[0], 64'sh7FFF_FFFE);
        chk("t3_last", beat_l[0], 1);

        run_cmd(32'd0, 32'd3, 32'd1, 1);
        chk("t4_beats", nbeats, 4);
        for (int i = 0; i < 4; i++) chk("t4_seq", beat_d[i], i);

        run_cmd(32'd5, 32'd0, 32'd0, 0);
        chk("t5_beats", nbeats, 0);
        chk("t5_err", err_at_done, 1);
        chk("t5_latency", done_cyc - acc_cyc, 1);

        run_cmd(32'd0, 32'd9, 32'hFFFF_FFFF, 0);
        chk("t6_beats", nbeats, 0);
        chk("t6_err", err_at_done, 1);

        run_cmd(32'd5, 32'd5, 32'd3, 0);
        chk("t7_beats", nbeats, 1);
        chk("t7_last", beat_l[0], 1);

        run_cmd(32'd0, 32'h8000_0000, 32'd1, 0);
        chk("t8_beats", nbeats, 0);
        chk("t8_err", err_at_done, 0);

        // reset after the second beat of 0..10
        rmode = 0;
        @(posedge clk); #1;
        cmd_first = 32'd0; cmd_limit = 32'd10; cmd_step = 32'd1; cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("t9_accept_timeout", 0, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t9_beats", nbeats, 2);
        chk("t9_no_done", done_cnt, 0);

        run_cmd(32'hFFFF_FFFE, 32'd2, 32'd2, 1);
        chk("t10_beats", nbeats, 3);
        chk("t10_b0", beat_d[0], -2);
        chk("t10_b2", beat_d[2], 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/signed_range_iter.md
Name: signed_range_iter

Overview:
- Hardware equivalent of a `for (i = first; i <= limit; i = i + step)` loop header, using signed integer semantics throughout.
- Accepts one loop command, then emits the index sequence over a valid/ready stream.
- Sits directly upstream of the loop-body consumer, an accumulator or update stage that counts or consumes each index.
- Its main job is to guarantee correct signed comparison: a positive start against a negative limit yields zero iterations, never a runaway loop.

Parameters:
- WIDTH, 32, bit width of first, limit, step and index; all treated as two's-complement signed.
- CNT_W, 16, width of the iteration counter, used only under the optional feature.

Ports:
- clk  input  1  single clock; all logic updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  block is idle and will accept a command.
- cmd_first  input  WIDTH  signed start value.
- cmd_limit  input  WIDTH  signed inclusive upper bound.
- cmd_step  input  WIDTH  signed increment; must be >= 1.
- idx_valid  output  1  idx_data is valid.
- idx_ready  input  1  consumer accepts the index.
- idx_data  output  WIDTH  current signed index.
- idx_last  output  1  qualifies the final index of the sequence.
- done  output  1  one-cycle pulse when the loop completes.
- err  output  1  one-cycle pulse, coincident with done, when the command was rejected as illegal.

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - On rst, state goes to IDLE.
  - cmd_ready=0 during the reset cycle and 1 on the cycle after.
  - idx_valid, idx_last, done and err are all 0; idx_data is 0.
  - rst overrides everything, including mid-sequence: the in-flight sequence is abandoned, no done pulse is produced, and the pending index is dropped.
- States: IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1.
  - Handshake occurs on cmd_valid & cmd_ready; first, limit and step are registered.
  - If step <= 0 (signed), go to FIN with err set.
  - Else if first > limit (signed compare), go to FIN with no beats.
  - Else go to RUN with idx_data = first.
- RUN:
  - idx_valid=1.
  - idx_last = (idx_data + step > limit), evaluated signed in WIDTH+1 bits so overflow past the signed maximum counts as exceeding the limit.
  - A beat transfers on idx_valid & idx_ready.
  - On a transfer with idx_last=1, go to FIN; on a transfer with idx_last=0, idx_data <= idx_data + step (no wrap possible, since overflow forces last).
  - With idx_ready low, idx_data, idx_valid and idx_last hold stable.
- FIN:
  - done=1 (and err if flagged) for exactly one cycle; cmd_ready=0.
  - Return to IDLE on the next cycle.
- Latency:
  - First index is valid on the cycle after command acceptance.
  - One index per cycle under continuous idx_ready.
  - done asserts on the cycle after the last beat transfers, or the cycle after acceptance for a zero-iteration or illegal command.
- Boundary conditions:
  - first == limit: exactly one beat, with idx_last=1.
  - limit = most-negative value with first >= 0: zero beats.
  - cmd_valid while busy: ignored; the source must hold it until cmd_ready.
- All comparisons are signed. An unsigned compare is a defect: it turns the zero-iteration case (e.g. 2 <= -1) into a near-infinite run.

Optional Feature:
- Macro: SIGNED_RANGE_ITER_COUNT_EN.
- Defined:
  - Adds output iter_count [CNT_W], cleared on rst and on command acceptance, incremented per transferred beat, saturating at all-ones.
  - iter_count holds its value from the done cycle until the next command is accepted.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- first=2, limit=-1, step=1 -> zero beats; done pulses 1 cycle after accept; err=0; iter_count=0.
- first=-3, limit=1, step=2, idx_ready=1 -> indices -3, -1, 1 on 3 consecutive cycles, idx_last only on 1; done the following cycle; iter_count=3.
- first=0x7FFFFFFE, limit=0x7FFFFFFF, step=2 -> single beat 0x7FFFFFFE with idx_last=1; no wrap to negative.
- first=0, limit=3, step=1, idx_ready toggling 1,0,0,1,... -> sequence 0..3 delivered in order; data stable while stalled.
- step=0 and, separately, step=-1 -> no beats; done=1 and err=1 together for one cycle; cmd_ready=1 the next cycle.
- rst asserted after the 2nd beat of first=0, limit=10 -> idx_valid=0 next cycle, no done pulse, cmd_ready=1 the cycle after rst deasserts; a new command runs correctly.
